qdi_1of2_sync_receiver: RTL and testbench
=========================================

// Module: qdi_1of2_sync_receiver
// PURPOSE
//  Clocked consumer of a 1-of-2 dual-rail QDI channel, e.g. the merged output of the two-client arbiter.
//  Runs the 4-phase handshake on Rx/Rxe and synchronises the rails into the CLK domain.
//  Presents each token as a bit on a valid/ready interface.
//  Keeps per-rail token counts and flags illegal codes and arbiter unfairness (long same-rail runs).
// PARAMETERS
//  SYNC_STAGES  2    flops per rail in the input synchroniser (>=2)
//  CNT_W        16   width of per-rail token counters (saturating)
//  MAX_RUN      8    consecutive same-rail tokens tolerated before run_err
//  TIMEOUT_CYC  1024 cycles allowed in any handshake phase (only with QDI_RX_TIMEOUT_EN)
// PORTS
//  CLK        in   1      sampling clock, rising edge
//  RESET      in   1      asynchronous, active-low reset
//  Rx         in   2      dual-rail data: 01 = bit 0, 10 = bit 1, 00 = neutral, 11 = illegal
//  Rxe        out  1      channel enable (1 = ready for data, 0 = acknowledge / request neutral)
//  dout       out  1      received bit
//  dout_valid out  1      dout holds an unconsumed token
//  dout_ready in   1      consumer accepts dout this cycle when dout_valid=1
//  cnt0       out  CNT_W  tokens received on rail 0
//  cnt1       out  CNT_W  tokens received on rail 1
//  illegal    out  1      sticky: synchronised Rx==11 seen
//  run_err    out  1      sticky: more than MAX_RUN consecutive tokens with the same value
//  timeout    out  1      sticky: handshake phase exceeded TIMEOUT_CYC (0 unless QDI_RX_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (RESET=0, async): Rxe=0, dout=0, dout_valid=0, cnt0=cnt1=0, illegal=run_err=timeout=0.
//    State=RST; synchronisers clear to 00.
//  Rx passes through SYNC_STAGES flops per rail; rs[1:0] denotes the synchronised rails. Only rs feeds the FSM.
//  FSM:
//    RST: one cycle after RESET release -> WAIT_DATA. Rxe rises on that edge.
//    WAIT_DATA (Rxe=1):
//      rs=01|10 and slot free (dout_valid=0 or dout_ready=1): capture dout=rs[1], dout_valid=1, Rxe<=0 -> WAIT_NTRL.
//      rs=01|10 and slot full: hold. Rxe stays 1; the sender holds data per QDI rules.
//      rs=11: illegal<=1, stay; no capture, no count.
//    WAIT_NTRL (Rxe=0):
//      rs=00: Rxe<=1 -> WAIT_DATA.
//      rs=11: set illegal.
//  Output slot: dout_valid clears when dout_valid & dout_ready, unless a new capture happens in the same cycle.
//    A new capture in that cycle keeps dout_valid=1 and updates dout.
//  Latency: Rx valid edge -> dout_valid=1 in SYNC_STAGES+1 CLK edges when the slot is free.
//    Neutral -> Rxe=1 in SYNC_STAGES+1 edges.
//  Counters: on each capture, cnt0 or cnt1 increments. Each saturates at 2^CNT_W-1 with no wrap.
//  Run check: run length is 1 on the first token and on any value change, +1 on a repeated value.
//    run_err sets on the capture that makes length = MAX_RUN+1. The run counter saturates at MAX_RUN+1.
//  Flags are sticky until reset. RESET mid-handshake aborts immediately; Rxe=0 until WAIT_DATA re-entered.
// CONFIGURATION
//  QDI_RX_TIMEOUT_EN defined: a cycle counter clears on every FSM state change and counts in WAIT_DATA and WAIT_NTRL.
//    In WAIT_DATA it counts only while rs!=00 (stalled capture).
//    Reaching TIMEOUT_CYC sets timeout (sticky); FSM behaviour is unchanged.
//  Undefined: no counter logic; timeout tied 0.
// TESTING
//  1. Reset 1000ps, release, Rx=00 -> Rxe=1 on the 1st edge after release; all outputs 0.
//  2. Rx=10, dout_ready=1; Rxe fall -> Rx=00 -> dout=1, dout_valid one cycle, cnt1=1, Rxe returns to 1.
//  3. dout_ready=0, send 01, then 10 -> first token held, Rxe stays 1 with Rx=10.
//     dout_ready=1 -> second captured; cnt0=1, cnt1=1.
//  4. Nine consecutive 01 tokens with MAX_RUN=8 -> run_err rises on the 9th capture; one 10 token does not clear it.
//  5. Rx=11 for 3 cycles in WAIT_DATA -> illegal=1, cnt0/cnt1 unchanged, no dout_valid.
//  6. QDI_RX_TIMEOUT_EN, TIMEOUT_CYC=16: hold Rx=01 after Rxe fall -> timeout=1 after 16 cycles in WAIT_NTRL.
//     Same test without the macro -> timeout=0.

Source files
------------

// File: rtl/qdi_1of2_sync_receiver.sv
// Clocked consumer of a 1-of-2 dual-rail QDI channel: 4-phase handshake, rail synchroniser,
// valid/ready token output, saturating per-rail counters and sticky error flags.
// Optional handshake-phase watchdog enabled by defining QDI_RX_TIMEOUT_EN.
module qdi_1of2_sync_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int MAX_RUN     = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       Rx,
  output logic             Rxe,
  output logic             dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             illegal,
  output logic             run_err,
  output logic             timeout
);

  if (SYNC_STAGES < 2 || CNT_W < 1 || MAX_RUN < 1 || TIMEOUT_CYC < 1) begin : gBadParams
    $error("qdi_1of2_sync_receiver: parameter out of range");
  end

  localparam int RUN_W = $clog2(MAX_RUN + 2);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {RST, WAIT_DATA, WAIT_NTRL} state_t;

  state_t           stateQ, stateD;
  logic [1:0]       syncReg [SYNC_STAGES];
  logic [1:0]       rs;
  logic             capture, illegalSeen, slotFree;
  logic [RUN_W-1:0] runLen, runNext;

  // NOTE: the synchroniser is a handful of flops, not a RAM, so clearing it on reset is free
  // and guarantees the FSM sees neutral until real data has crossed.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) syncReg[i] <= 2'b00;
    end else begin
      syncReg[0] <= Rx;
      for (int i = 1; i < SYNC_STAGES; i++) syncReg[i] <= syncReg[i-1];
    end
  end

  assign rs       = syncReg[SYNC_STAGES-1];
  assign slotFree = !dout_valid || dout_ready;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    stateD      = stateQ;
    capture     = 1'b0;
    illegalSeen = 1'b0;
    unique case (stateQ)
      RST: stateD = WAIT_DATA;
      WAIT_DATA: begin
        if (rs == 2'b01 || rs == 2'b10) begin
          if (slotFree) begin
            capture = 1'b1;
            stateD  = WAIT_NTRL;
          end
        end else if (rs == 2'b11) begin
          illegalSeen = 1'b1;
        end
      end
      WAIT_NTRL: begin
        if (rs == 2'b00)      stateD      = WAIT_DATA;
        else if (rs == 2'b11) illegalSeen = 1'b1;
      end
      default: stateD = RST;
    endcase
  end

  // Run length restarts on the very first token (runLen==0) and on every value change.
  always_comb begin
    runNext = runLen;
    if (runLen == '0 || rs[1] != dout) runNext = RUN_W'(1);
    else if (runLen != RUN_MAX)        runNext = runLen + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stateQ     <= RST;
      Rxe        <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      cnt0       <= '0;
      cnt1       <= '0;
      illegal    <= 1'b0;
      run_err    <= 1'b0;
      runLen     <= '0;
    end else begin
      stateQ <= stateD;
      Rxe    <= (stateD == WAIT_DATA);
      if (illegalSeen) illegal <= 1'b1;
      if (capture) begin
        dout       <= rs[1];
        dout_valid <= 1'b1;
        runLen     <= runNext;
        if (runNext == RUN_MAX) run_err <= 1'b1;
        if (rs[1]) begin
          if (cnt1 != CNT_MAX) cnt1 <= cnt1 + 1'b1;
        end else begin
          if (cnt0 != CNT_MAX) cnt0 <= cnt0 + 1'b1;
        end
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

`ifdef QDI_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] toCnt;
  logic            toCounting, stateChange;

  // A WAIT_DATA phase only counts as stalled while the sender is actually presenting something.
  assign toCounting  = (stateQ == WAIT_NTRL) || (stateQ == WAIT_DATA && rs != 2'b00);
  assign stateChange = (stateD != stateQ);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      toCnt   <= '0;
      timeout <= 1'b0;
    end else if (stateChange) begin
      toCnt <= '0;
    end else if (toCounting && toCnt != TO_W'(TIMEOUT_CYC)) begin
      toCnt <= toCnt + 1'b1;
      if (toCnt == TO_LAST) timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_qdi_1of2_sync_receiver.sv
// Self-checking bench for qdi_1of2_sync_receiver: directed handshake scenarios plus randomized
// token traffic, compared every cycle against a token-level reference model and a send/receive scoreboard.
`timescale 1ns/1ps
module tb_qdi_1of2_sync_receiver;

  localparam int SS = 2;
  localparam int CW = 4;
  localparam int MR = 8;
  localparam int TO = 16;
  localparam int SAT = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [1:0]    Rx;
  logic          Rxe, dout, dout_valid, dout_ready;
  logic [CW-1:0] cnt0, cnt1;
  logic          illegal, run_err, timeout;

  qdi_1of2_sync_receiver #(
    .SYNC_STAGES(SS), .CNT_W(CW), .MAX_RUN(MR), .TIMEOUT_CYC(TO)
  ) dut (
    .CLK(CLK), .RESET(RESET), .Rx(Rx), .Rxe(Rxe), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .cnt0(cnt0), .cnt1(cnt1), .illegal(illegal),
    .run_err(run_err), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  int  nChecks = 0;
  int  nPass   = 0;
  bit  checking = 0;
  int  readyMode = 0;    // 0 = never ready, 1 = always ready, 2 = random
  bit  sentQ[$];         // tokens put on the channel, in order

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (token level) ----------------
  logic [1:0] mHist [SS];
  int  mPhase = 0;       // 0 = just out of reset, 1 = accepting data, 2 = waiting for neutral
  bit  mDout = 0, mValid = 0, mIll = 0, mRunErr = 0, mTo = 0;
  int  tot0 = 0, tot1 = 0;
  bit  capQ[$];          // recent captured values, for run-length evaluation
`ifdef QDI_RX_TIMEOUT_EN
  int  mToCnt = 0;
`endif

  always @(posedge CLK or negedge RESET) begin : refModel
    logic [1:0] rs;
    int prevPhase;
    bit cap;
    int run;
    if (!RESET) begin
      foreach (mHist[i]) mHist[i] = 2'b00;
      mPhase = 0; mDout = 0; mValid = 0; mIll = 0; mRunErr = 0; mTo = 0;
      tot0 = 0; tot1 = 0; capQ.delete();
`ifdef QDI_RX_TIMEOUT_EN
      mToCnt = 0;
`endif
    end else begin
      // NOTE: the bench model uses blocking assignments on purpose; it is evaluated as a program.
      rs = mHist[SS-1];
      for (int i = SS - 1; i > 0; i--) mHist[i] = mHist[i-1];
      mHist[0] = Rx;
      prevPhase = mPhase;
      cap = 0;
      if (mPhase == 0) mPhase = 1;
      else if (rs == 2'b11) mIll = 1;
      else if (mPhase == 1 && rs != 2'b00 && (!mValid || dout_ready)) begin cap = 1; mPhase = 2; end
      else if (mPhase == 2 && rs == 2'b00) mPhase = 1;
`ifdef QDI_RX_TIMEOUT_EN
      if (mPhase != prevPhase) mToCnt = 0;
      else if ((prevPhase == 1 && rs != 2'b00) || prevPhase == 2) begin
        mToCnt++;
        if (mToCnt >= TO) mTo = 1;
      end
`endif
      if (cap) begin
        mDout = rs[1];
        if (rs[1]) tot1++; else tot0++;
        capQ.push_back(rs[1]);
        run = 0;
        for (int i = capQ.size() - 1; i >= 0 && capQ[i] == rs[1]; i--) run++;
        if (run > MR) mRunErr = 1;
        if (capQ.size() > MR + 1) void'(capQ.pop_front());
        mValid = 1;
      end else if (mValid && dout_ready) begin
        mValid = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge CLK);
    if (checking) begin
      check("Rxe",        Rxe,        32'(mPhase == 1));
      check("dout",       dout,       mDout);
      check("dout_valid", dout_valid, mValid);
      check("cnt0",       cnt0,       (tot0 > SAT) ? SAT : tot0);
      check("cnt1",       cnt1,       (tot1 > SAT) ? SAT : tot1);
      check("illegal",    illegal,    mIll);
      check("run_err",    run_err,    mRunErr);
      check("timeout",    timeout,    mTo);
      if (dout_valid && dout_ready) begin
        if (sentQ.size() == 0) check("pop_without_token", sentQ.size(), 1);
        else check("token_order", dout, sentQ.pop_front());
      end
    end
  end

  // ready is changed just after the rising edge so it is stable at every sampling point
  initial begin
    dout_ready = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (readyMode)
        0:       dout_ready = 1'b0;
        1:       dout_ready = 1'b1;
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", nPass, nChecks);
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic waitRxe(input logic v);
    int n = 0;
    while (Rxe !== v && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("rxe_wait_bound", Rxe, v);
  endtask

  task automatic sendToken(input bit b, input int gap);
    waitRxe(1'b1);
    Rx = b ? 2'b10 : 2'b01;
    sentQ.push_back(b);
    waitRxe(1'b0);
    repeat (gap) @(negedge CLK);
    Rx = 2'b00;
  endtask

  task automatic doReset();
    @(negedge CLK);
    #2 RESET = 1'b0;
    Rx = 2'b00;
    readyMode = 0;
    sentQ.delete();
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bit v;
    RESET = 1'b1;
    Rx = 2'b00;
    #0.5 RESET = 1'b0;
    #1 RESET = 1'b1;
    #0.1;
    check("rst_Rxe", Rxe, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_cnt", {cnt0, cnt1}, 0);
    checking = 1;
    @(negedge CLK);
    check("first_edge_Rxe", Rxe, 1);
    check("first_edge_flags", {illegal, run_err, timeout, dout, dout_valid}, 0);

    // bit 1 with a free slot: latency in both handshake directions
    readyMode = 1;
    Rx = 2'b10;
    sentQ.push_back(1'b1);
    n = 0;
    do begin @(negedge CLK); n++; end while (!dout_valid && n < 20);
    check("data_latency", n, SS + 1);
    check("t2_dout", dout, 1);
    check("t2_cnt1", cnt1, 1);
    check("t2_Rxe_low", Rxe, 0);
    Rx = 2'b00;
    @(negedge CLK);
    check("t2_valid_one_cycle", dout_valid, 0);
    n = 1;
    while (!Rxe && n < 20) begin @(negedge CLK); n++; end
    check("neutral_latency", n, SS + 1);

    // backpressure: second token held on the channel while the slot is full
    doReset();
    sendToken(1'b0, 1);
    waitRxe(1'b1);
    Rx = 2'b10;
    sentQ.push_back(1'b1);
    repeat (8) @(negedge CLK);
    check("t3_held_Rxe", Rxe, 1);
    check("t3_held_valid", dout_valid, 1);
    check("t3_held_dout", dout, 0);
    check("t3_held_cnt1", cnt1, 0);
    readyMode = 1;
    waitRxe(1'b0);
    check("t3_cnt0", cnt0, 1);
    check("t3_cnt1", cnt1, 1);
    check("t3_dout", dout, 1);
    Rx = 2'b00;

    // long same-value run, counter saturation
    doReset();
    readyMode = 1;
    for (int i = 0; i < 20; i++) begin
      sendToken(1'b0, i % 3);
      if (i == MR - 1) check("run_err_at_max", run_err, 0);
      if (i == MR)     check("run_err_past_max", run_err, 1);
    end
    check("cnt0_saturated", cnt0, SAT);
    sendToken(1'b1, 0);
    check("run_err_sticky", run_err, 1);
    check("t4_cnt1", cnt1, 1);

    // illegal code while waiting for data
    doReset();
    waitRxe(1'b1);
    Rx = 2'b11;
    repeat (3) @(negedge CLK);
    Rx = 2'b00;
    repeat (6) @(negedge CLK);
    check("t5_illegal", illegal, 1);
    check("t5_cnts", {cnt0, cnt1}, 0);
    check("t5_no_valid", dout_valid, 0);
    check("t5_Rxe", Rxe, 1);

    // sender never returns to neutral
    doReset();
    readyMode = 1;
    waitRxe(1'b1);
    Rx = 2'b01;
    sentQ.push_back(1'b0);
    waitRxe(1'b0);
    repeat (TO + 4) @(negedge CLK);
`ifdef QDI_RX_TIMEOUT_EN
    check("t6_timeout", timeout, 1);
`else
    check("t6_timeout", timeout, 0);
`endif
    Rx = 2'b00;
    waitRxe(1'b1);

    // randomized traffic with random backpressure and run-prone data
    doReset();
    readyMode = 2;
    v = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) v = ~v;
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      sendToken(v, $urandom_range(0, 3));
    end
    readyMode = 1;
    repeat (10) @(negedge CLK);
    check("random_drained", sentQ.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
